irq_pending: RTL and testbench
==============================

# irq_pending

Interrupt request front end for the 8-to-3 priority encoder stage. Eight asynchronous request lines are synchronized, rising-edge detected and latched as pending bits. The masked pending vector drives the encoder input. A three-state controller raises an interrupt, accepts the acknowledge carrying the encoder's 3-bit index, moves that source to in-service and waits for end-of-interrupt.

## Interface
Parameters:
- none; width is fixed at 8 sources, 3-bit index

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- irq  in  8  asynchronous request lines, rising-edge sensitive, bit 7 highest priority
- mask_we  in  1  mask register write strobe
- mask_din  in  8  new mask value, 1 = source masked
- ack  in  1  single-cycle acknowledge from the CPU side
- ack_id  in  3  index being acknowledged (the encoder output), sampled when ack=1
- eoi  in  1  single-cycle end-of-interrupt
- pend  out  8  pending & ~mask, drives the priority encoder input
- int_out  out  1  interrupt request, high while in REQ
- isr  out  8  one-hot in-service vector, all zero when nothing in service
- busy  out  1  high while in SERVICE

## Operation
- Sync path per bit: s1 <= irq, s2 <= s1, s3 <= s2; edge = s2 & ~s3.
- pending[k] <= 1 on edge[k]. Masked sources still latch pending. They are hidden from pend only.
- mask <= mask_din when mask_we. The new mask is reflected in pend from the next cycle.
- pend = pending & ~mask, combinational from registers.
- FSM states:
  - IDLE: go to REQ when |pend.
  - REQ: int_out=1.
    - On ack with pend[ack_id]=1: clear pending[ack_id], set isr to the one-hot of ack_id, go to SERVICE.
    - On ack with pend[ack_id]=0 (spurious or masked): no pending/isr change, go to IDLE.
    - If pend falls to 0 without ack (masked away): go to IDLE.
  - SERVICE: busy=1. On eoi: isr <= 0, go to IDLE.
- ack outside REQ is ignored. eoi outside SERVICE is ignored.
- Set beats clear: if edge[k] and an ack clear of bit k occur in the same cycle, pending[k] stays 1.
- New edges during REQ/SERVICE latch normally. A repeated edge on an already pending bit is absorbed (no count).
- Nested interrupts are not supported: a higher-priority pend during SERVICE waits for eoi.

## Timing
- Reset (rst_n=0 at a clock edge): s1..s3=0, pending=0, mask=8'h00, isr=0, state=IDLE. Therefore pend=0, int_out=0, busy=0. Reset mid-operation aborts any REQ/SERVICE immediately.
- irq held high through reset is seen as a rising edge after release, and is latched pending.
- Latency, with irq rising before clock edge E1:
  - edge true after E2
  - pending/pend set after E3
  - state REQ, int_out=1 after E4
- ack sampled at edge A: pending clear, isr set, busy=1 and int_out=0 after A.
- eoi at edge B: isr=0, busy=0 after B. If pend is nonzero, REQ and int_out=1 follow after B+1.
- irq pulses shorter than one clock period may be missed. The source must hold irq ≥ 2 cycles.
- Simultaneous ack and mask_we in REQ: ack is evaluated against the old mask.

## Test plan
- Reset, then irq=8'h04 held: pend=8'h04 after E3, int_out=1 after E4. ack with ack_id=2 → isr=8'h04, pend=0, busy=1. eoi → isr=0, IDLE, int_out stays 0.
- irq=8'h81 rising together → pend=8'h81. ack_id=7 → pend=8'h01, isr=8'h80. eoi → int_out=1 two edges later. ack_id=0 → isr=8'h01.
- mask_din=8'hF0 written, then irq=8'h10 → pending latched but pend=0, int_out=0. Write mask 8'h00 → pend=8'h10 next cycle, int_out=1 the cycle after.
- Spurious ack: in REQ with pend=8'h02, ack with ack_id=5 → isr stays 0, state IDLE, then REQ again after one edge since pend=8'h02.
- Same-cycle ack of bit 3 while a new edge on bit 3 arrives → pending[3] remains 1, isr=8'h08. After eoi, int_out reasserts.
- rst_n=0 for one edge during SERVICE with pend=8'h40 → all outputs 0 after that edge, mask=8'h00, with no residual isr.

Source files
------------

// File: rtl/irq_pending.sv
// Interrupt front end: synchronizes eight request lines, latches rising edges as
// pending bits, and sequences request / acknowledge / end-of-interrupt for one source.
module irq_pending (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irq,
    input  logic       mask_we,
    input  logic [7:0] mask_din,
    input  logic       ack,
    input  logic [2:0] ack_id,
    input  logic       eoi,
    output logic [7:0] pend,
    output logic       int_out,
    output logic [7:0] isr,
    output logic       busy
);

    // Handshake: int_out stays high in REQ until a single-cycle ack arrives;
    // busy stays high in SERVICE until a single-cycle eoi arrives.
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] s1, s2, s3;
    logic [7:0] rise;
    logic [7:0] pending;
    logic [7:0] mask;
    logic [7:0] ack_onehot;
    logic [7:0] clr;
    logic       ack_hit;

    assign rise       = s2 & ~s3;
    assign pend       = pending & ~mask;
    assign ack_onehot = 8'(1) << ack_id;
    assign ack_hit    = (state == REQ) && ack && pend[ack_id];
    assign clr        = ack_hit ? ack_onehot : 8'h00;
    assign int_out    = (state == REQ);
    assign busy       = (state == SERVICE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1      <= 8'h00;
            s2      <= 8'h00;
            s3      <= 8'h00;
            pending <= 8'h00;
            mask    <= 8'h00;
            isr     <= 8'h00;
            state   <= IDLE;
        end else begin
            s1      <= irq;
            s2      <= s1;
            s3      <= s2;
            // A fresh edge on the bit being acknowledged keeps it pending.
            pending <= (pending & ~clr) | rise;
            if (mask_we)
                mask <= mask_din;
            if (ack_hit)
                isr <= ack_onehot;
            else if ((state == SERVICE) && eoi)
                isr <= 8'h00;
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (|pend)
                    state_next = REQ;
            end
            REQ: begin
                if (ack_hit)
                    state_next = SERVICE;
                else if (ack || (pend == 8'h00))
                    state_next = IDLE;
            end
            SERVICE: begin
                if (eoi)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_irq_pending.sv
// Bench for irq_pending: directed scenarios plus a randomized run against a
// behavioural model tracking request/service as output-level flags.
module tb_irq_pending;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq;
    logic       mask_we;
    logic [7:0] mask_din;
    logic       ack;
    logic [2:0] ack_id;
    logic       eoi;
    logic [7:0] pend;
    logic       int_out;
    logic [7:0] isr;
    logic       busy;

    int checks = 0;
    int errors = 0;

    irq_pending dut (
        .clk(clk), .rst_n(rst_n), .irq(irq), .mask_we(mask_we), .mask_din(mask_din),
        .ack(ack), .ack_id(ack_id), .eoi(eoi),
        .pend(pend), .int_out(int_out), .isr(isr), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: three-sample history of irq, pending set, mask,
    // and the two externally visible phases (requesting, in service).
    logic [7:0] hist [3];
    logic [7:0] m_pending, m_mask, m_isr;
    logic       m_int, m_busy;
    logic [7:0] m_rise, m_vis;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) hist[i] = 8'h00;
            m_pending = 8'h00; m_mask = 8'h00; m_isr = 8'h00;
            m_int = 1'b0; m_busy = 1'b0;
        end else begin
            m_rise = hist[1] & ~hist[2];
            m_vis  = m_pending & ~m_mask;
            if (m_int) begin
                if (ack) begin
                    if (m_vis[ack_id]) begin
                        m_pending[ack_id] = 1'b0;
                        m_isr = 8'h00;
                        m_isr[ack_id] = 1'b1;
                        m_busy = 1'b1;
                    end
                    m_int = 1'b0;
                end else if (m_vis == 8'h00) begin
                    m_int = 1'b0;
                end
            end else if (m_busy) begin
                if (eoi) begin
                    m_isr = 8'h00;
                    m_busy = 1'b0;
                end
            end else if (m_vis != 8'h00) begin
                m_int = 1'b1;
            end
            m_pending = m_pending | m_rise;
            if (mask_we) m_mask = mask_din;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = irq;
        end
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic pulse_ack(input logic [2:0] id);
        ack = 1'b1; ack_id = id;
        tick();
        ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; irq = 8'h20;
        tick(2);
        checks++;
        if ({pend, int_out, isr, busy} !== 18'h0) begin
            errors++;
            $display("FAIL reset_outputs got pend=%h int=%b isr=%h busy=%b exp all zero", pend, int_out, isr, busy);
        end
        rst_n = 1'b1;
        tick(3);
        checks++;
        if (pend !== 8'h20 || int_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_irq_pend got pend=%h int=%b exp pend=20 int=0", pend, int_out);
        end
        tick();
        checks++;
        if (int_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_held_irq_int got %b exp 1", int_out);
        end
        pulse_ack(3'd5);
        pulse_eoi();
        irq = 8'h00;
        tick(3);
    endtask

    task automatic test_basic();
        irq = 8'h04;
        tick(2);
        checks++;
        if (pend !== 8'h00) begin
            errors++;
            $display("FAIL basic_pend_e2 got %h exp 00", pend);
        end
        tick();
        checks++;
        if (pend !== 8'h04 || int_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_pend_e3 got pend=%h int=%b exp pend=04 int=0", pend, int_out);
        end
        tick();
        checks++;
        if (int_out !== 1'b1) begin
            errors++;
            $display("FAIL basic_int_e4 got %b exp 1", int_out);
        end
        pulse_ack(3'd2);
        checks++;
        if (isr !== 8'h04 || pend !== 8'h00 || busy !== 1'b1 || int_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack got isr=%h pend=%h busy=%b int=%b exp 04 00 1 0", isr, pend, busy, int_out);
        end
        pulse_eoi();
        tick();
        checks++;
        if (isr !== 8'h00 || busy !== 1'b0 || int_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_eoi got isr=%h busy=%b int=%b exp 00 0 0", isr, busy, int_out);
        end
        irq = 8'h00;
        tick(3);
    endtask

    task automatic test_two_sources();
        irq = 8'h81;
        tick(3);
        checks++;
        if (pend !== 8'h81) begin
            errors++;
            $display("FAIL two_pend got %h exp 81", pend);
        end
        tick();
        pulse_ack(3'd7);
        checks++;
        if (pend !== 8'h01 || isr !== 8'h80) begin
            errors++;
            $display("FAIL two_ack7 got pend=%h isr=%h exp 01 80", pend, isr);
        end
        pulse_eoi();
        checks++;
        if (int_out !== 1'b0 || isr !== 8'h00) begin
            errors++;
            $display("FAIL two_eoi got int=%b isr=%h exp 0 00", int_out, isr);
        end
        tick();
        checks++;
        if (int_out !== 1'b1) begin
            errors++;
            $display("FAIL two_rereq got %b exp 1", int_out);
        end
        pulse_ack(3'd0);
        checks++;
        if (isr !== 8'h01 || pend !== 8'h00) begin
            errors++;
            $display("FAIL two_ack0 got isr=%h pend=%h exp 01 00", isr, pend);
        end
        pulse_eoi();
        irq = 8'h00;
        tick(3);
    endtask

    task automatic test_mask();
        mask_we = 1'b1; mask_din = 8'hF0;
        tick();
        mask_we = 1'b0;
        irq = 8'h10;
        tick(4);
        checks++;
        if (pend !== 8'h00 || int_out !== 1'b0) begin
            errors++;
            $display("FAIL mask_hidden got pend=%h int=%b exp 00 0", pend, int_out);
        end
        mask_we = 1'b1; mask_din = 8'h00;
        tick();
        mask_we = 1'b0;
        checks++;
        if (pend !== 8'h10 || int_out !== 1'b0) begin
            errors++;
            $display("FAIL mask_unmask got pend=%h int=%b exp 10 0", pend, int_out);
        end
        tick();
        checks++;
        if (int_out !== 1'b1) begin
            errors++;
            $display("FAIL mask_int got %b exp 1", int_out);
        end
        pulse_ack(3'd4);
        pulse_eoi();
        irq = 8'h00;
        tick(3);
    endtask

    task automatic test_spurious();
        irq = 8'h02;
        tick(4);
        pulse_ack(3'd5);
        checks++;
        if (isr !== 8'h00 || int_out !== 1'b0 || busy !== 1'b0 || pend !== 8'h02) begin
            errors++;
            $display("FAIL spurious_ack got isr=%h int=%b busy=%b pend=%h exp 00 0 0 02", isr, int_out, busy, pend);
        end
        tick();
        checks++;
        if (int_out !== 1'b1) begin
            errors++;
            $display("FAIL spurious_rereq got %b exp 1", int_out);
        end
        pulse_ack(3'd1);
        pulse_eoi();
        irq = 8'h00;
        tick(3);
    endtask

    task automatic test_set_beats_clear();
        irq = 8'h08;
        tick(4);
        irq = 8'h00;
        tick(3);
        irq = 8'h08;
        tick(2);
        pulse_ack(3'd3);
        checks++;
        if (pend !== 8'h08 || isr !== 8'h08 || busy !== 1'b1) begin
            errors++;
            $display("FAIL sbc_ack got pend=%h isr=%h busy=%b exp 08 08 1", pend, isr, busy);
        end
        pulse_eoi();
        tick();
        checks++;
        if (int_out !== 1'b1) begin
            errors++;
            $display("FAIL sbc_rereq got %b exp 1", int_out);
        end
        pulse_ack(3'd3);
        pulse_eoi();
        irq = 8'h00;
        tick(3);
    endtask

    task automatic test_reset_mid();
        mask_we = 1'b1; mask_din = 8'h01;
        tick();
        mask_we = 1'b0;
        irq = 8'hC0;
        tick(4);
        pulse_ack(3'd7);
        checks++;
        if (busy !== 1'b1 || pend !== 8'h40) begin
            errors++;
            $display("FAIL rstmid_setup got busy=%b pend=%h exp 1 40", busy, pend);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({pend, int_out, isr, busy} !== 18'h0) begin
            errors++;
            $display("FAIL rstmid_outputs got pend=%h int=%b isr=%h busy=%b exp all zero", pend, int_out, isr, busy);
        end
        rst_n = 1'b1; irq = 8'h00;
        tick(3);
        irq = 8'h01;
        tick(3);
        checks++;
        if (pend !== 8'h01) begin
            errors++;
            $display("FAIL rstmid_mask_cleared got pend=%h exp 01", pend);
        end
        pulse_ack(3'd0);
        tick();
        pulse_eoi();
        irq = 8'h00;
        tick(3);
    endtask

    task automatic test_random();
        int hold [8];
        for (int b = 0; b < 8; b++) hold[b] = 0;
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            for (int b = 0; b < 8; b++) begin
                hold[b]++;
                if (hold[b] >= 2 && $urandom_range(0, 5) == 0) begin
                    irq[b] = ~irq[b];
                    hold[b] = 0;
                end
            end
            ack = ($urandom_range(0, 3) == 0);
            ack_id = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) begin
                for (int b = 0; b < 8; b++)
                    if (m_pending[b] && !m_mask[b]) ack_id = 3'(b);
            end
            eoi = ($urandom_range(0, 3) == 0);
            mask_we = ($urandom_range(0, 15) == 0);
            mask_din = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            tick();
            checks++;
            if (pend !== (m_pending & ~m_mask) || int_out !== m_int || isr !== m_isr || busy !== m_busy) begin
                errors++;
                $display("FAIL random_cycle%0d got pend=%h int=%b isr=%h busy=%b exp %h %b %h %b",
                         n, pend, int_out, isr, busy, m_pending & ~m_mask, m_int, m_isr, m_busy);
            end
        end
        rst_n = 1'b1; ack = 1'b0; eoi = 1'b0; mask_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq = 8'h00; mask_we = 1'b0; mask_din = 8'h00;
        ack = 1'b0; ack_id = 3'd0; eoi = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_two_sources();
        test_mask();
        test_spurious();
        test_set_beats_clear();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
